// File: rtl/ahb_master_if_pkg.sv
`default_nettype none
//==============================================================================
// Module      : ahb_master_if_pkg
// Description : Shared AHB encodings (HTRANS, HRESP, HBURST, HPROT) and the
//               retry-limit constants used by the single-transfer AHB master.
// Revision    : 1.0 - initial release
//==============================================================================

`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_RESP_BITS
`define AHB_RESP_BITS 2
`endif

package ahb_master_if_pkg;

  // HTRANS encodings. Only single transfers are issued, so BUSY and SEQ are
  // never driven.
  localparam logic [`AHB_TRANS_BITS-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [`AHB_TRANS_BITS-1:0] HTRANS_NONSEQ = 2'b10;

  // HRESP encodings.
  localparam logic [`AHB_RESP_BITS-1:0] HRESP_OKAY  = 2'b00;
  localparam logic [`AHB_RESP_BITS-1:0] HRESP_ERROR = 2'b01;
  localparam logic [`AHB_RESP_BITS-1:0] HRESP_RETRY = 2'b10;
  localparam logic [`AHB_RESP_BITS-1:0] HRESP_SPLIT = 2'b11;

  // HBURST encoding for a single transfer.
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Privileged data access, non-bufferable, non-cacheable.
  localparam logic [3:0] HPROT_PRIV_DATA = 4'b0011;

  // Retry bookkeeping: a RETRY/SPLIT seen with the counter at RETRY_LIMIT
  // terminates the request with an error instead of reissuing it.
  localparam int         RETRY_CNT_W = 4;
  localparam logic [3:0] RETRY_LIMIT = 4'd8;

  // True for the two responses that ask the master to reissue the transfer.
  function automatic logic resp_is_retry(input logic [`AHB_RESP_BITS-1:0] resp);
    return (resp == HRESP_RETRY) || (resp == HRESP_SPLIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_master_if.sv
`default_nettype none
//==============================================================================
// Module      : ahb_master_if
// Description : Single-transfer AHB bus master. Accepts one request from the
//               core, arbitrates for the bus, runs one NONSEQ/SINGLE transfer,
//               handles the two-cycle ERROR/RETRY/SPLIT responses (reissuing
//               up to a retry limit) and returns a one-cycle completion pulse.
// Revision    : 1.0 - initial release
//==============================================================================

`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_RESP_BITS
`define AHB_RESP_BITS 2
`endif

module ahb_master_if
  import ahb_master_if_pkg::*;
(
  input  logic                       HCLK,
  input  logic                       HRESET,
  // core request side
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic                       req_lock,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  input  logic [2:0]                 req_size,
  // core response side
  output logic                       rsp_valid,
  output logic                       rsp_error,
  output logic [31:0]                rsp_rdata,
  // arbiter
  output logic                       HBUSREQ,
  output logic                       HLOCK,
  input  logic                       HGRANT,
  // AHB slave response
  input  logic                       HREADY,
  input  logic [`AHB_RESP_BITS-1:0]  HRESP,
  input  logic [31:0]                HRDATA,
  // AHB address/data phase
  output logic [`AHB_TRANS_BITS-1:0] HTRANS,
  output logic [31:0]                HADDR,
  output logic [31:0]                HWDATA,
  output logic                       HWRITE,
  output logic [2:0]                 HSIZE,
  output logic [2:0]                 HBURST,
  output logic [3:0]                 HPROT
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSREQ = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_RESP2  = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Request captured at acceptance; reissues after RETRY/SPLIT reuse it.
  logic [31:0]            req_addr_q;
  logic [31:0]            req_wdata_q;
  logic                   req_write_q;
  logic                   req_lock_q;
  logic [2:0]             req_size_q;
  logic [RETRY_CNT_W-1:0] retry_q;

  // AHB control outputs are registered so they hold their last value
  // outside the phase that owns them.
  logic [31:0] haddr_q;
  logic [31:0] hwdata_q;
  logic        hwrite_q;
  logic [2:0]  hsize_q;
  logic [2:0]  hburst_q;
  logic [3:0]  hprot_q;

  logic        rsp_valid_q;
  logic        rsp_error_q;
  logic [31:0] rsp_rdata_q;

  // Per-cycle control strobes from the FSM.
  logic accept;      // request handshake completes this cycle
  logic load_aphase; // entering the address phase
  logic load_dphase; // entering the data phase
  logic resolve;     // slave response is final this cycle
  logic done;        // completion pulse next cycle
  logic done_err;    // completion carries an error
  logic cap_rdata;   // capture HRDATA for a successful read
  logic retry_inc;   // reissue the transfer
  logic bus_own;     // requesting / holding the bus

  // State register; reset aborts any in-flight transfer.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and transfer-control strobes.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    load_aphase = 1'b0;
    load_dphase = 1'b0;
    done        = 1'b0;
    done_err    = 1'b0;
    cap_rdata   = 1'b0;
    retry_inc   = 1'b0;
    resolve     = HREADY && ((state_q == ST_DATA) || (state_q == ST_RESP2));

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ST_BUSREQ;
        end
      end
      ST_BUSREQ: begin
        // Ownership is taken only on an HREADY edge with grant, so grant
        // cannot be lost once in the address phase.
        if (HGRANT && HREADY) begin
          load_aphase = 1'b1;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          load_dphase = 1'b1;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        // First cycle of a two-cycle non-OKAY response.
        if (!HREADY && (HRESP != HRESP_OKAY)) begin
          state_d = ST_RESP2;
        end
      end
      ST_RESP2: begin
        // Waits for the HREADY edge; handled by the resolve logic below.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Final response from the slave in DATA or the second response cycle.
    if (resolve) begin
      if (HRESP == HRESP_OKAY) begin
        done      = 1'b1;
        cap_rdata = !req_write_q;
        state_d   = ST_IDLE;
      end else if (resp_is_retry(HRESP) && (retry_q != RETRY_LIMIT)) begin
        retry_inc = 1'b1;
        state_d   = ST_BUSREQ;
      end else begin
        done     = 1'b1;
        done_err = 1'b1;
        state_d  = ST_IDLE;
      end
    end
  end

  // Latch the request on acceptance.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      req_write_q <= 1'b0;
      req_lock_q  <= 1'b0;
      req_size_q  <= 3'd0;
    end else if (accept) begin
      req_addr_q  <= req_addr;
      req_wdata_q <= req_wdata;
      req_write_q <= req_write;
      req_lock_q  <= req_lock;
      req_size_q  <= req_size;
    end
  end

  // Retry counter: cleared per request, bumped on each reissue.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      retry_q <= '0;
    end else if (accept) begin
      retry_q <= '0;
    end else if (retry_inc) begin
      retry_q <= retry_q + 4'd1;
    end
  end

  // Address-phase controls, loaded as the address phase starts and held after.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      haddr_q  <= 32'd0;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'd0;
      hburst_q <= 3'd0;
      hprot_q  <= 4'd0;
    end else if (load_aphase) begin
      haddr_q  <= req_addr_q;
      hwrite_q <= req_write_q;
      hsize_q  <= req_size_q;
      hburst_q <= HBURST_SINGLE;
      hprot_q  <= HPROT_PRIV_DATA;
    end
  end

  // Write data, driven from the data phase onward and held afterwards.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hwdata_q <= 32'd0;
    end else if (load_dphase) begin
      hwdata_q <= req_wdata_q;
    end
  end

  // Completion pulse, error flag and read-data capture.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      rsp_valid_q <= done;
      rsp_error_q <= done && done_err;
      if (cap_rdata) begin
        rsp_rdata_q <= HRDATA;
      end
    end
  end

  assign bus_own   = (state_q == ST_BUSREQ) || (state_q == ST_ADDR);

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

  assign HBUSREQ   = bus_own;
  assign HLOCK     = bus_own && req_lock_q;
  assign HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = haddr_q;
  assign HWDATA    = hwdata_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = hburst_q;
  assign HPROT     = hprot_q;

endmodule

`default_nettype wire

// File: doc/ahb_master_if.md
AHB_MASTER_IF -- requirements
Module: ahb_master_if

Interface
REQ-001 SHALL have port HCLK  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port HRESET  in  1  reset; asynchronous and active-high.
REQ-003 SHALL have ports req_valid/req_ready  in/out  1/1  core request handshake; transfer on a cycle where both are 1.
REQ-004 SHALL have ports req_write, req_lock  in  1 each  request is a write / request is a locked transfer.
REQ-005 SHALL have ports req_addr, req_wdata  in  32 each  request address and write data; req_size  in  3  HSIZE encoding.
REQ-006 SHALL have ports rsp_valid, rsp_error  out  1 each  one-cycle completion pulse and its error flag; rsp_rdata  out  32  read data.
REQ-007 SHALL have ports HBUSREQ, HLOCK  out  1 each  arbiter request and lock; HGRANT  in  1  arbiter grant.
REQ-008 SHALL have ports HREADY  in  1 and HRESP  in  `AHB_RESP_BITS; HRDATA  in  32.
REQ-009 SHALL have ports HTRANS  out  `AHB_TRANS_BITS; HADDR, HWDATA  out  32; HWRITE  out  1; HSIZE, HBURST  out  3; HPROT  out  4.

Function
REQ-010 SHALL implement FSM states IDLE, BUSREQ, ADDR, DATA and RESP2.
REQ-011 SHALL drive req_ready=1 only in IDLE; an accepted request is latched (addr, wdata, write, size, lock), and the FSM enters BUSREQ on the next edge.
REQ-012 SHALL drive HBUSREQ=1 in BUSREQ and ADDR, and HLOCK=latched lock in the same states; both SHALL be 0 elsewhere.
REQ-013 SHALL move BUSREQ->ADDR on an edge where HGRANT=1 and HREADY=1; otherwise it SHALL remain in BUSREQ.
REQ-014 SHALL drive, in ADDR, HTRANS=NONSEQ, HADDR, HWRITE and HSIZE from the latched values, HBURST=SINGLE and HPROT=4'b0011.
REQ-015 SHALL drive HTRANS=IDLE in every state other than ADDR, with HADDR, HWRITE and HSIZE holding their last values.
REQ-016 SHALL move ADDR->DATA on an edge with HREADY=1; while HREADY=0 it SHALL hold the ADDR outputs stable.
REQ-017 SHALL drive HWDATA=latched wdata in DATA and RESP2; the HWDATA value outside these states is don't-care and is held.
REQ-018 SHALL, in DATA on an edge with HREADY=1 and HRESP=OKAY: register HRDATA (reads) into rsp_rdata, pulse rsp_valid=1 with rsp_error=0 in the next cycle, and return to IDLE.
REQ-019 SHALL, in DATA on an edge with HREADY=0 and HRESP!=OKAY, enter RESP2 (first cycle of a two-cycle response).
REQ-020 SHALL, in RESP2 on the HREADY=1 edge: for ERROR, pulse rsp_valid with rsp_error=1 and go to IDLE; for RETRY or SPLIT, increment the retry counter and go to BUSREQ to reissue the identical transfer.
REQ-021 SHALL use a 4-bit retry counter that clears on request acceptance; a RETRY/SPLIT arriving when the count is 8 SHALL instead complete with rsp_error=1.
REQ-022 SHALL hold rsp_rdata until the next completion; on write completion rsp_rdata SHALL be unchanged.
REQ-023 SHALL give an unstalled latency from accept to rsp_valid of 4 cycles when HGRANT is already 1.
REQ-024 SHALL accept a new request in the cycle in which rsp_valid is high; this is the back-to-back boundary.
REQ-025 SHALL, when HGRANT drops while in BUSREQ, keep waiting; losing grant cannot occur in ADDR because ownership was sampled at the HREADY edge.

Reset
REQ-026 SHALL, while HRESET=1, immediately set the state to IDLE, req_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0, HBUSREQ=0, HLOCK=0, HTRANS=IDLE, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=0, and the retry counter=0.
REQ-027 SHALL abort an in-flight transfer on reset mid-operation, with no response issued afterwards.

Structure
REQ-028 SHALL take HTRANS/HRESP/HBURST encodings from the shared AHB package/defines, alongside `AHB_TRANS_BITS and `AHB_RESP_BITS; FSM state enum local.
REQ-029 SHALL be implemented as a single module; no sub-module is required.

Verification
REQ-030 SHALL verify a read with HGRANT=1 and HREADY=1 always, addr 0x0000_1000 and HRDATA=0xDEAD_BEEF: one NONSEQ cycle is observed and rsp_valid pulses with rdata 0xDEAD_BEEF 4 cycles after accept.
REQ-031 SHALL verify a write with HGRANT delayed 3 cycles, addr 0x20 and wdata 0x1234_5678: HBUSREQ stays high 3+ cycles, and HWDATA=0x1234_5678 is driven in the data phase.
REQ-032 SHALL verify HREADY=0 for 2 cycles during ADDR: HADDR and HTRANS stay stable, and completion is delayed 2 cycles.
REQ-033 SHALL verify a 2-cycle ERROR response in DATA: rsp_valid=1 with rsp_error=1 follows and the FSM is in IDLE.
REQ-034 SHALL verify RETRY on every attempt: the transfer is reissued 8 times, then the 9th RETRY yields rsp_error=1.
REQ-035 SHALL verify HRESET asserted in DATA: all outputs take reset values asynchronously and no rsp_valid occurs.
